// File: rtl/clk_div_monitor_if.sv
// Signal bundle between the divided clock under test, its control and the monitor results.
interface clk_div_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             clk_mon;
   logic             clr;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic [7:0]       edge_cnt;
   logic             win_done;
   logic             win_ok;
   logic             err_period;
   logic             locked;

   modport master (
      output clk_mon, clr,
      input  period, period_vld, edge_cnt, win_done, win_ok, err_period, locked
   );

   modport slave (
      input  clk_mon, clr,
      output period, period_vld, edge_cnt, win_done, win_ok, err_period, locked
   );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures periods and per-window edge counts of a clk_in-synchronous divided clock,
// flags out-of-range periods and derives a lock indication from consecutive good windows.
module clk_div_monitor #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned WIN       = 87,
   parameter int unsigned EDGES_EXP = 10,
   parameter int unsigned PMIN      = 8,
   parameter int unsigned PMAX      = 9,
   parameter int unsigned LOCK_N    = 2
) (
   input logic               clk_in,
   input logic               rst,
   clk_div_monitor_if.slave  mon
);
   localparam int unsigned      WCNT_W   = (WIN > 2) ? $clog2(WIN) : 1;
   localparam logic [CNT_W-1:0] PCNT_MAX = '1;
   localparam logic [CNT_W-1:0] PMIN_C   = CNT_W'(PMIN);
   localparam logic [CNT_W-1:0] PMAX_C   = CNT_W'(PMAX);
   localparam logic [WCNT_W-1:0] WLAST   = WCNT_W'(WIN - 1);
   localparam logic [7:0]       EDGES_C  = 8'(EDGES_EXP);
   localparam logic [1:0]       LOCK_C   = 2'(LOCK_N);

   typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

   logic              clk_d;
   logic              seen;
   logic [CNT_W-1:0]  pcnt;
   logic [WCNT_W-1:0] wcnt;
   logic [7:0]        ecnt;
   logic [1:0]        gcnt;
   lock_state_e       lock_q;

   logic [CNT_W-1:0]  period_q;
   logic              period_vld_q;
   logic [7:0]        edge_cnt_q;
   logic              win_done_q;
   logic              win_ok_q;
   logic              err_q;

   logic              rise;
   logic              bad_period;
   logic              win_close;
   logic              good_close;
   logic [7:0]        ecnt_inc;
   logic [1:0]        gcnt_nxt;

   assign rise       = mon.clk_mon & ~clk_d;
   assign bad_period = rise & seen & ((pcnt < PMIN_C) | (pcnt > PMAX_C));
   assign win_close  = (wcnt == WLAST);
   assign ecnt_inc   = (rise && ecnt != 8'hFF) ? ecnt + 8'd1 : ecnt;
   assign good_close = (ecnt_inc == EDGES_C);

   // A bad period overrides a good window closing in the same cycle.
   always_comb begin
      gcnt_nxt = gcnt;
      if (bad_period) begin
         gcnt_nxt = '0;
      end else if (win_close) begin
         if (!good_close)          gcnt_nxt = '0;
         else if (gcnt != LOCK_C)  gcnt_nxt = gcnt + 2'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         clk_d        <= 1'b0;
         seen         <= 1'b0;
         pcnt         <= '0;
         wcnt         <= '0;
         ecnt         <= '0;
         gcnt         <= '0;
         lock_q       <= StUnlocked;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         edge_cnt_q   <= '0;
         win_done_q   <= 1'b0;
         win_ok_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // Keeps sampling through clr so the cycle after clr sees no false rise.
         clk_d <= mon.clk_mon;
         if (mon.clr) begin
            seen         <= 1'b0;
            pcnt         <= '0;
            wcnt         <= '0;
            ecnt         <= '0;
            gcnt         <= '0;
            lock_q       <= StUnlocked;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            edge_cnt_q   <= '0;
            win_done_q   <= 1'b0;
            win_ok_q     <= 1'b0;
            err_q        <= 1'b0;
         end else begin
            if (rise)                   pcnt <= CNT_W'(1);
            else if (pcnt != PCNT_MAX)  pcnt <= pcnt + CNT_W'(1);
            seen         <= seen | rise;
            period_vld_q <= rise & seen;
            if (rise && seen) period_q <= pcnt;
            if (bad_period)   err_q    <= 1'b1;
            win_done_q <= win_close;
            if (win_close) begin
               wcnt       <= '0;
               ecnt       <= '0;
               edge_cnt_q <= ecnt_inc;
               win_ok_q   <= good_close;
            end else begin
               wcnt <= wcnt + WCNT_W'(1);
               ecnt <= ecnt_inc;
            end
            gcnt   <= gcnt_nxt;
            lock_q <= (gcnt_nxt == LOCK_C) ? StLocked : StUnlocked;
         end
      end
   end

   assign mon.period     = period_q;
   assign mon.period_vld = period_vld_q;
   assign mon.edge_cnt   = edge_cnt_q;
   assign mon.win_done   = win_done_q;
   assign mon.win_ok     = win_ok_q;
   assign mon.err_period = err_q;
   assign mon.locked     = (lock_q == StLocked);
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: /8 stream, short-period injection, coincident
// rise at window close, clr during a rise, long low stretch and asynchronous reset.
module tb_clk_div_monitor;
   localparam int unsigned WIN = 80;

   logic clk_in = 1'b0;
   logic rst    = 1'b0;

   clk_div_monitor_if #(.CNT_W(8)) mif ();

   clk_div_monitor #(
      .CNT_W     (8),
      .WIN       (WIN),
      .EDGES_EXP (10),
      .PMIN      (8),
      .PMAX      (9),
      .LOCK_N    (2)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .mon    (mif)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int wbase = 0;
   int ph = 0;
   int cur_per = 8;
   int one_shot = 0;
   int last_rise = 0;
   bit seen_m = 1'b0;
   bit prev_v = 1'b0;
   bit clr_now = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".period"}, 32'(mif.period), 0);
      chk({tag, ".period_vld"}, 32'(mif.period_vld), 0);
      chk({tag, ".edge_cnt"}, 32'(mif.edge_cnt), 0);
      chk({tag, ".win_done"}, 32'(mif.win_done), 0);
      chk({tag, ".win_ok"}, 32'(mif.win_ok), 0);
      chk({tag, ".err_period"}, 32'(mif.err_period), 0);
      chk({tag, ".locked"}, 32'(mif.locked), 0);
   endtask

   // One clk_in cycle of stimulus: high for the first 4 cycles of each period.
   task automatic tick();
      bit v, rise_e, vld_e, wd_e;
      int per_e;
      v      = (ph < 4);
      rise_e = v && !prev_v;
      vld_e  = 1'b0;
      per_e  = 0;
      if (rise_e && !clr_now) begin
         vld_e     = seen_m;
         per_e     = (cyc + 1 - last_rise > 255) ? 255 : cyc + 1 - last_rise;
         seen_m    = 1'b1;
         last_rise = cyc + 1;
      end
      mif.clk_mon = v;
      mif.clr     = clr_now;
      @(posedge clk_in);
      #1;
      cyc++;
      prev_v = v;
      if (clr_now) begin
         seen_m = 1'b0;
         wbase  = cyc;
      end
      wd_e = !clr_now && ((cyc - wbase) % WIN == 0);
      if (rise_e || mif.period_vld) begin
         chk("period_vld", 32'(mif.period_vld), 32'(vld_e));
         if (vld_e) chk("period", 32'(mif.period), 32'(per_e));
      end
      if (wd_e || mif.win_done) chk("win_done", 32'(mif.win_done), 32'(wd_e));
      ph++;
      if (ph >= cur_per) begin
         ph       = 0;
         cur_per  = (one_shot != 0) ? one_shot : 8;
         one_shot = 0;
      end
   endtask

   task automatic run_until(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      mif.clk_mon = 1'b0;
      mif.clr     = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk_all_zero("reset");
      rst = 1'b1;

      // Ideal /8 stream: 10 edges per 80-cycle window, lock after the second window.
      run_until(80);
      chk("w1.win_done", 32'(mif.win_done), 1);
      chk("w1.edge_cnt", 32'(mif.edge_cnt), 10);
      chk("w1.win_ok", 32'(mif.win_ok), 1);
      chk("w1.locked", 32'(mif.locked), 0);
      run_until(160);
      chk("w2.edge_cnt", 32'(mif.edge_cnt), 10);
      chk("w2.win_ok", 32'(mif.win_ok), 1);
      chk("w2.locked", 32'(mif.locked), 1);
      chk("w2.err", 32'(mif.err_period), 0);

      // 7-cycle period from 169 to 175, reported at the rise on cycle 176.
      one_shot = 7;
      run_until(175);
      chk("pre_inj.locked", 32'(mif.locked), 1);
      run_until(176);
      chk("inj.period", 32'(mif.period), 7);
      chk("inj.err", 32'(mif.err_period), 1);
      chk("inj.locked", 32'(mif.locked), 0);

      // Rise lands on the closing cycle 240 and belongs to window 3 (11 edges).
      run_until(240);
      chk("w3.win_done", 32'(mif.win_done), 1);
      chk("w3.edge_cnt", 32'(mif.edge_cnt), 11);
      chk("w3.win_ok", 32'(mif.win_ok), 0);
      chk("w3.locked", 32'(mif.locked), 0);
      run_until(320);
      chk("w4.edge_cnt", 32'(mif.edge_cnt), 10);
      chk("w4.win_ok", 32'(mif.win_ok), 1);
      chk("w4.locked", 32'(mif.locked), 0);
      run_until(400);
      chk("w5.edge_cnt", 32'(mif.edge_cnt), 10);
      chk("w5.locked", 32'(mif.locked), 1);
      chk("w5.err_sticky", 32'(mif.err_period), 1);

      // clr coincident with the rise on cycle 408.
      run_until(407);
      clr_now = 1'b1;
      tick();
      clr_now = 1'b0;
      chk_all_zero("clr");
      run_until(487);
      chk("clr.win_early", 32'(mif.win_done), 0);
      run_until(488);
      chk("clr.win_done", 32'(mif.win_done), 1);
      chk("clr.edge_cnt", 32'(mif.edge_cnt), 10);
      chk("clr.win_ok", 32'(mif.win_ok), 1);
      chk("clr.locked", 32'(mif.locked), 0);
      chk("clr.err", 32'(mif.err_period), 0);

      // Period of 304 starting at 496: low for 300 cycles, next rise at 800.
      one_shot = 304;
      run_until(568);
      chk("low1.edge_cnt", 32'(mif.edge_cnt), 1);
      chk("low1.win_ok", 32'(mif.win_ok), 0);
      run_until(648);
      chk("low2.edge_cnt", 32'(mif.edge_cnt), 0);
      chk("low2.win_ok", 32'(mif.win_ok), 0);
      chk("low2.locked", 32'(mif.locked), 0);
      run_until(799);
      chk("low.err_before", 32'(mif.err_period), 0);
      run_until(800);
      chk("sat.period_vld", 32'(mif.period_vld), 1);
      chk("sat.period", 32'(mif.period), 255);
      chk("sat.err", 32'(mif.err_period), 1);
      run_until(808);
      chk("w_low3.edge_cnt", 32'(mif.edge_cnt), 2);
      chk("w_low3.win_done", 32'(mif.win_done), 1);

      // Asynchronous reset mid-operation clears outputs without waiting for a clock edge.
      run_until(810);
      rst = 1'b0;
      #1;
      chk_all_zero("async_rst");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
